// File: rtl/clock_pkg.sv
// Shared constants and types for the time-of-day counter: field indices,
// display mode codes and BCD field limits.
package clock_pkg;

    localparam int SEC  = 0;
    localparam int MIN  = 1;
    localparam int HOUR = 2;

    localparam logic [3:0] TIME     = 4'b0001;
    localparam logic [3:0] CALENDAR = 4'b0010;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Wide enough for CLK_DIV-1 at the largest legal divider (2^26).
    localparam int PRESC_W = 26;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

endpackage

// File: rtl/bcd_field.sv
// Two-digit BCD up/down counter wrapping at 00..MAX. Carry-out is raised only
// when a time advance wraps the field; manual adjusts wrap silently.
module bcd_field
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic  Clk,
    input  logic  Reset,
    input  logic  i_adv,
    input  logic  i_inc,
    input  logic  i_dec,
    output bcd2_t o_value,
    output logic  o_carry
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    bcd2_t r_value;
    bcd2_t w_next;
    logic  w_at_max;
    logic  w_at_zero;
    logic  w_up;

    assign w_at_max  = (r_value.tens == MAX_T) && (r_value.units == MAX_U);
    assign w_at_zero = (r_value == '0);
    assign w_up      = i_inc | i_adv;
    assign o_carry   = i_adv & ~i_inc & ~i_dec & w_at_max;
    assign o_value   = r_value;

    // Increment (or advance) takes precedence over decrement.
    always_comb begin
        w_next = r_value;
        if (w_up) begin
            if (w_at_max) begin
                w_next = '0;
            end else if (r_value.units == 4'd9) begin
                w_next.units = 4'd0;
                w_next.tens  = r_value.tens + 4'd1;
            end else begin
                w_next.units = r_value.units + 4'd1;
            end
        end else if (i_dec) begin
            if (w_at_zero) begin
                w_next.tens  = MAX_T;
                w_next.units = MAX_U;
            end else if (r_value.units == 4'd0) begin
                w_next.units = 4'd9;
                w_next.tens  = r_value.tens - 4'd1;
            end else begin
                w_next.units = r_value.units - 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

endmodule

// File: rtl/daytime_counter.sv
// Time-of-day counter (HH:MM:SS in BCD) driven by a 1 s prescaler, with
// per-field manual adjust and a one-cycle day-rollover pulse.
module daytime_counter
    import clock_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50_000_000,
    parameter logic [3:0]  MODE_CODE = TIME
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        run_en,
    input  logic [2:0]  cnt_inc,
    input  logic [2:0]  cnt_dec,
    output logic        full_flag,
    output logic [31:0] Data
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               r_full;
    logic [31:0]        r_data;
    logic               w_tick;
    logic               w_adjust;
    logic               w_sec_adjust;
    logic [2:0]         w_adv;
    logic [2:0]         w_carry;
    bcd2_t              w_digits [3];

    assign w_tick       = run_en && (r_presc == PRESC_LAST);
    assign w_adjust     = |{cnt_inc, cnt_dec};
    assign w_sec_adjust = cnt_inc[SEC] | cnt_dec[SEC];

    // A seconds adjust restarts the second so the next tick is a full period away.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
        end else if (w_sec_adjust || w_tick) begin
            r_presc <= '0;
        end else if (run_en) begin
            r_presc <= r_presc + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            localparam int FMAX = (gi == HOUR) ? HOUR_MAX :
                                  (gi == MIN)  ? MIN_MAX  : SEC_MAX;

            // Any adjust pulse swallows a coincident tick.
            if (gi == SEC) begin : g_src
                assign w_adv[gi] = w_tick & ~w_adjust;
            end else begin : g_src
                assign w_adv[gi] = w_carry[gi-1];
            end

            bcd_field #(
                .MAX (FMAX)
            ) u_field (
                .Clk     (Clk),
                .Reset   (Reset),
                .i_adv   (w_adv[gi]),
                .i_inc   (cnt_inc[gi]),
                .i_dec   (cnt_dec[gi]),
                .o_value (w_digits[gi]),
                .o_carry (w_carry[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_full <= 1'b0;
            r_data <= {24'h0, 4'b0000, MODE_CODE};
        end else begin
            r_full <= w_carry[HOUR];
            r_data <= {w_digits[SEC].units,  w_digits[SEC].tens,
                       w_digits[MIN].units,  w_digits[MIN].tens,
                       w_digits[HOUR].units, w_digits[HOUR].tens,
                       4'b0000, MODE_CODE};
        end
    end

    assign full_flag = r_full;
    assign Data      = r_data;

endmodule

// File: tb/tb_daytime_counter.sv
// Directed self-checking bench for daytime_counter with a 4-cycle second.
`timescale 1ns/1ps
module tb_daytime_counter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        run_en = 1'b0;
    logic [2:0]  cnt_inc = '0;
    logic [2:0]  cnt_dec = '0;
    logic        full_flag;
    logic [31:0] Data;

    int checks = 0;
    int errors = 0;

    daytime_counter #(
        .CLK_DIV (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .run_en    (run_en),
        .cnt_inc   (cnt_inc),
        .cnt_dec   (cnt_dec),
        .full_flag (full_flag),
        .Data      (Data)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_data(input int h, input int m, input int s);
        return {4'(s % 10), 4'(s / 10), 4'(m % 10), 4'(m / 10),
                4'(h % 10), 4'(h / 10), 4'h0, 4'h1};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        run_en = 1'b0;
        cnt_inc = '0;
        cnt_dec = '0;
        step(2);
        Reset = 1'b0;
    endtask

    task automatic pulse(input logic [2:0] inc, input logic [2:0] dec, output logic flag_seen);
        cnt_inc = inc;
        cnt_dec = dec;
        step(1);
        flag_seen = full_flag;
        cnt_inc = '0;
        cnt_dec = '0;
        step(1);
        $display("adjust inc=%b dec=%b -> Data=%h", inc, dec, Data);
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if (Data !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_data: got %h want %h", Data, 32'h0000_0001);
        end
        checks++;
        if (full_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_flag: got %b want 0", full_flag);
        end
        $display("reset: Data=%h full_flag=%b", Data, full_flag);
    endtask

    task automatic test_tick();
        do_reset();
        run_en = 1'b1;
        step(4);
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL tick_latency: got %h want %h", Data, exp_data(0, 0, 0));
        end
        step(1);
        checks++;
        if (Data !== exp_data(0, 0, 1)) begin
            errors++;
            $display("FAIL tick_first: got %h want %h", Data, exp_data(0, 0, 1));
        end
        step(4);
        checks++;
        if (Data !== exp_data(0, 0, 2)) begin
            errors++;
            $display("FAIL tick_second: got %h want %h", Data, exp_data(0, 0, 2));
        end
        $display("tick: Data=%h", Data);
    endtask

    task automatic test_freeze();
        do_reset();
        run_en = 1'b1;
        step(2);
        run_en = 1'b0;
        step(10);
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL freeze_hold: got %h want %h", Data, exp_data(0, 0, 0));
        end
        run_en = 1'b1;
        step(2);
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL freeze_early: got %h want %h", Data, exp_data(0, 0, 0));
        end
        step(1);
        checks++;
        if (Data !== exp_data(0, 0, 1)) begin
            errors++;
            $display("FAIL freeze_resume: got %h want %h", Data, exp_data(0, 0, 1));
        end
        $display("freeze: Data=%h", Data);
    endtask

    task automatic test_rollover();
        logic f;
        do_reset();
        pulse(3'b000, 3'b111, f);
        pulse(3'b000, 3'b001, f);
        checks++;
        if (Data !== exp_data(23, 59, 58)) begin
            errors++;
            $display("FAIL roll_preset: got %h want %h", Data, exp_data(23, 59, 58));
        end
        run_en = 1'b1;
        step(5);
        checks++;
        if (Data !== exp_data(23, 59, 59)) begin
            errors++;
            $display("FAIL roll_5959: got %h want %h", Data, exp_data(23, 59, 59));
        end
        step(2);
        checks++;
        if (full_flag !== 1'b0) begin
            errors++;
            $display("FAIL roll_flag_early: got %b want 0", full_flag);
        end
        step(1);
        checks++;
        if (full_flag !== 1'b1) begin
            errors++;
            $display("FAIL roll_flag_set: got %b want 1", full_flag);
        end
        step(1);
        checks++;
        if (full_flag !== 1'b0) begin
            errors++;
            $display("FAIL roll_flag_width: got %b want 0", full_flag);
        end
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL roll_zero: got %h want %h", Data, exp_data(0, 0, 0));
        end
        $display("rollover: Data=%h full_flag=%b", Data, full_flag);
    endtask

    task automatic test_adjust();
        logic f;
        do_reset();
        pulse(3'b000, 3'b111, f);
        checks++;
        if (Data !== exp_data(23, 59, 59)) begin
            errors++;
            $display("FAIL adj_dec_all: got %h want %h", Data, exp_data(23, 59, 59));
        end
        pulse(3'b100, 3'b000, f);
        checks++;
        if (f !== 1'b0) begin
            errors++;
            $display("FAIL adj_hour_wrap_flag: got %b want 0", f);
        end
        checks++;
        if (Data !== exp_data(0, 59, 59)) begin
            errors++;
            $display("FAIL adj_hour_wrap: got %h want %h", Data, exp_data(0, 59, 59));
        end
        pulse(3'b010, 3'b000, f);
        checks++;
        if (Data !== exp_data(0, 0, 59)) begin
            errors++;
            $display("FAIL adj_min_nocarry: got %h want %h", Data, exp_data(0, 0, 59));
        end
        pulse(3'b000, 3'b010, f);
        checks++;
        if (Data !== exp_data(0, 59, 59)) begin
            errors++;
            $display("FAIL adj_min_borrow: got %h want %h", Data, exp_data(0, 59, 59));
        end
        pulse(3'b001, 3'b110, f);
        checks++;
        if (Data !== exp_data(23, 58, 0)) begin
            errors++;
            $display("FAIL adj_mixed: got %h want %h", Data, exp_data(23, 58, 0));
        end
        pulse(3'b100, 3'b100, f);
        checks++;
        if (Data !== exp_data(0, 58, 0)) begin
            errors++;
            $display("FAIL adj_inc_wins: got %h want %h", Data, exp_data(0, 58, 0));
        end
        checks++;
        if (f !== 1'b0) begin
            errors++;
            $display("FAIL adj_inc_wins_flag: got %b want 0", f);
        end
    endtask

    task automatic test_collision();
        logic f;
        do_reset();
        pulse(3'b000, 3'b001, f);
        run_en = 1'b1;
        step(3);
        cnt_inc = 3'b001;
        cnt_dec = 3'b001;
        step(1);
        cnt_inc = '0;
        cnt_dec = '0;
        checks++;
        if (full_flag !== 1'b0) begin
            errors++;
            $display("FAIL coll_flag: got %b want 0", full_flag);
        end
        step(1);
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL coll_value: got %h want %h", Data, exp_data(0, 0, 0));
        end
        step(3);
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL coll_early_tick: got %h want %h", Data, exp_data(0, 0, 0));
        end
        step(1);
        checks++;
        if (Data !== exp_data(0, 0, 1)) begin
            errors++;
            $display("FAIL coll_next_tick: got %h want %h", Data, exp_data(0, 0, 1));
        end
        $display("collision: Data=%h", Data);
    endtask

    task automatic test_sec_adjust_clears();
        do_reset();
        run_en = 1'b1;
        step(2);
        cnt_inc = 3'b001;
        step(1);
        cnt_inc = '0;
        step(4);
        checks++;
        if (Data !== exp_data(0, 0, 1)) begin
            errors++;
            $display("FAIL secadj_early: got %h want %h", Data, exp_data(0, 0, 1));
        end
        step(1);
        checks++;
        if (Data !== exp_data(0, 0, 2)) begin
            errors++;
            $display("FAIL secadj_tick: got %h want %h", Data, exp_data(0, 0, 2));
        end
        $display("sec adjust restart: Data=%h", Data);
    endtask

    task automatic test_carry();
        logic f;
        do_reset();
        pulse(3'b000, 3'b011, f);
        run_en = 1'b1;
        step(5);
        checks++;
        if (Data !== exp_data(1, 0, 0)) begin
            errors++;
            $display("FAIL carry_hour: got %h want %h", Data, exp_data(1, 0, 0));
        end
        checks++;
        if (full_flag !== 1'b0) begin
            errors++;
            $display("FAIL carry_flag: got %b want 0", full_flag);
        end
        $display("carry: Data=%h", Data);
    endtask

    task automatic test_async_reset();
        logic f;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            pulse(3'b000, {(i < 12) ? 1'b1 : 1'b0, 1'b1, (i < 4) ? 1'b1 : 1'b0}, f);
        end
        checks++;
        if (Data !== exp_data(12, 34, 56)) begin
            errors++;
            $display("FAIL async_preset: got %h want %h", Data, exp_data(12, 34, 56));
        end
        run_en = 1'b1;
        step(2);
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if (Data !== 32'h0000_0001) begin
            errors++;
            $display("FAIL async_data: got %h want %h", Data, 32'h0000_0001);
        end
        checks++;
        if (full_flag !== 1'b0) begin
            errors++;
            $display("FAIL async_flag: got %b want 0", full_flag);
        end
        step(1);
        Reset = 1'b0;
        step(4);
        checks++;
        if (Data !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL async_release_early: got %h want %h", Data, exp_data(0, 0, 0));
        end
        step(1);
        checks++;
        if (Data !== exp_data(0, 0, 1)) begin
            errors++;
            $display("FAIL async_release_tick: got %h want %h", Data, exp_data(0, 0, 1));
        end
        $display("async reset: Data=%h", Data);
    endtask

    initial begin
        test_reset();
        test_tick();
        test_freeze();
        test_rollover();
        test_adjust();
        test_collision();
        test_sec_adjust_clears();
        test_carry();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
